// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_pkg;

    // Number of radix-2 iterations per multiply or divide.
    localparam int ITER = 32;

    // Operation codes presented on md_unit.op.
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } md_op_e;

    // FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One radix-2 multiply (shift-add) or restoring-divide (shift-subtract) iteration.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to register acc_next.
//
// Ports:
//   is_div   - 1 selects the divide step, 0 the multiply step
//   acc      - multiply: {partial product, remaining multiplier bits}
//              divide:   {partial remainder, remaining dividend bits / quotient so far}
//   opnd     - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_next - accumulator after this iteration
module md_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]   sum;     // partial product + multiplicand, with carry
    logic [XLEN:0]   rem_sh;  // partial remainder shifted left with next dividend bit
    logic [XLEN-1:0] diff;    // rem_sh - divisor, only meaningful when q_bit is set
    logic            q_bit;

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        q_bit  = (rem_sh >= {1'b0, opnd});
        // When q_bit is set the true difference is below the divisor, so
        // the low XLEN bits hold it exactly.
        diff   = rem_sh[XLEN-1:0] - opnd;

        if (is_div) begin
            // Quotient bits enter at the bottom as dividend bits leave the top.
            if (q_bit) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            // Consume the multiplier LSB; the carry shifts into the top.
            if (acc[0]) begin
                acc_next = {sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative signed/unsigned MULT/DIV with architectural HI/LO and MTHI/MTLO writes.
// Latency: start accepted at edge N, busy N+1..N+33, done and new HI/LO in N+34.
// Backpressure: start is ignored while busy; flush aborts without touching HI/LO.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   start, op        - request and operation code (md_pkg::md_op_e)
//   rs_val, rt_val   - dividend/multiplicand and divisor/multiplier
//   flush            - abort in-flight op; wins over a simultaneous start
//   busy             - iterative op in progress (decoded from state only)
//   done             - one-cycle pulse, HI/LO updated on the preceding edge
//   hi, lo           - architectural HI/LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_e         state, state_nxt;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic              is_div;
    logic              sgn_q;   // product or quotient must be negated
    logic              sgn_r;   // remainder must be negated
    logic              div0;

    // Decode of the incoming request.
    logic              accept;
    logic              wr_mthi;
    logic              wr_mtlo;
    logic              op_iter;
    logic              op_signed;
    logic              op_div;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    // Sign-corrected results, consumed in FIX.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign busy = (state != IDLE);

    md_step #(.XLEN(XLEN)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    // Operation decode and operand magnitudes.
    always_comb begin
        op_iter   = 1'b0;
        op_signed = 1'b0;
        op_div    = 1'b0;
        case (op)
            MULT:    begin op_iter = 1'b1; op_signed = 1'b1; end
            MULTU:   begin op_iter = 1'b1; end
            DIV:     begin op_iter = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
            DIVU:    begin op_iter = 1'b1; op_div = 1'b1; end
            default: begin op_iter = 1'b0; end
        endcase
        a_neg = op_signed & rs_val[XLEN-1];
        b_neg = op_signed & rt_val[XLEN-1];
        mag_a = a_neg ? -rs_val : rs_val;
        mag_b = b_neg ? -rt_val : rt_val;
    end

    // Next state and request acceptance.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_mthi   = 1'b0;
        wr_mtlo   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (op_iter) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else if (op == MTHI) begin
                        wr_mthi = 1'b1;
                    end else if (op == MTLO) begin
                        wr_mtlo = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == 6'(ITER - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Sign correction of the finished magnitudes. The most negative value
    // negates to itself, which yields the 0x8000_0000 / -1 overflow result
    // without a special case.
    always_comb begin
        prod = sgn_q ? -acc : acc;
        quot = sgn_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sgn_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                cnt    <= '0;
                is_div <= op_div;
                sgn_q  <= a_neg ^ b_neg;
                sgn_r  <= a_neg;
                div0   <= op_div && (rt_val == '0);
                if (op_div) begin
                    acc  <= {{XLEN{1'b0}}, mag_a};
                    opnd <= mag_b;
                end else begin
                    acc  <= {{XLEN{1'b0}}, mag_b};
                    opnd <= mag_a;
                end
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= cnt + 6'd1;
            end

            if (wr_mthi) begin
                hi <= rs_val;
            end
            if (wr_mtlo) begin
                lo <= rs_val;
            end

            if (state == FIX && !flush) begin
                done <= 1'b1;
                if (is_div) begin
                    // A zero divisor leaves the dividend magnitude in the
                    // remainder, so HI already restores rs; only the
                    // quotient needs forcing past the sign correction.
                    lo <= div0 ? '1 : quot;
                    hi <= rem;
                end else begin
                    hi <= prod[2*XLEN-1:XLEN];
                    lo <= prod[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        md_op_e      vop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the request in that cycle (N) and returns
    // at the negedge of the cycle where done is seen, with lat = k for N+k.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_err);
        op       = o;
        rs_val   = a;
        rt_val   = b;
        start    = 1'b1;
        lat      = -1;
        busy_err = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                if (busy) busy_err++;
                lat = k;
                break;
            end
            if (!busy) busy_err++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int berr;
        int ndone;

        tbl[0]  = '{MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1]  = '{MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        tbl[4]  = '{DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        tbl[5]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[7]  = '{DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        tbl[8]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[9]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[10] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[11] = '{DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
        tbl[12] = '{MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 3'd0;
        rs_val = '0;
        rt_val = '0;

        repeat (2) @(negedge clk);
        chk("rst_hi",   hi,   32'h0);
        chk("rst_lo",   lo,   32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back in each done cycle.
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].vop, tbl[i].a, tbl[i].b, lat, berr);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd34);
            chk($sformatf("v%0d_busy", i), 32'(berr), 32'd0);
            chk($sformatf("v%0d_hi", i), hi, tbl[i].e_hi);
            chk($sformatf("v%0d_lo", i), lo, tbl[i].e_lo);
        end
        @(negedge clk);
        chk("done_pulse_width", {31'b0, done}, 32'h0);

        // MTLO / MTHI while idle.
        op = MTLO; rs_val = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo",   lo,   32'hCAFE_F00D);
        chk("mtlo_hi",   hi,   32'hFFFF_FFFF);
        chk("mtlo_busy", {31'b0, busy}, 32'h0);
        chk("mtlo_done", {31'b0, done}, 32'h0);
        op = MTHI; rs_val = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'h1111_1111);
        chk("mthi_lo", lo, 32'hCAFE_F00D);

        // Flush mid-multiply at N+10.
        op = MULT; rs_val = 32'd5; rt_val = 32'd7; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("flush_busy_before", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", {31'b0, busy}, 32'h0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush_no_done", 32'(ndone), 32'd0);
        chk("flush_hi", hi, 32'h1111_1111);
        chk("flush_lo", lo, 32'hCAFE_F00D);

        // Flush beats a simultaneous start, both iterative and MTLO.
        op = MULT; rs_val = 32'd5; rt_val = 32'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_start_busy", {31'b0, busy}, 32'h0);
        op = MTLO; rs_val = 32'h0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_mtlo_lo", lo, 32'hCAFE_F00D);

        // Start during busy is ignored.
        op = MULTU; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 5) begin
                op = DIV; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
            end
        end
        chk("ignored_latency", 32'(lat), 32'd34);
        chk("ignored_hi", hi, 32'h0);
        chk("ignored_lo", lo, 32'd42);
        @(negedge clk);
        chk("ignored_not_queued", {31'b0, busy}, 32'h0);

        // Asynchronous reset mid-operation.
        op = MTHI; rs_val = 32'h5A5A_5A5A; start = 1'b1;
        @(negedge clk);
        op = MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("prerst_hi", hi, 32'h5A5A_5A5A);
        rst = 1'b1;
        #1;
        chk("midrst_hi",   hi,   32'h0);
        chk("midrst_lo",   lo,   32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);

        // Recovery after reset.
        run_op(DIVU, 32'd100, 32'd7, lat, berr);
        chk("recover_latency", 32'(lat), 32'd34);
        chk("recover_hi", hi, 32'd2);
        chk("recover_lo", lo, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with architectural HI/LO registers, placed in the execute stage directly downstream of the register file. It consumes the two register read operands (rs, rt), runs signed or unsigned MULT/DIV over a fixed multi-cycle sequence, and holds the 64-bit result in HI/LO for MFHI/MFLO. A busy/done handshake lets the pipeline control logic stall dependent instructions.

## Interface

Parameters:
- `XLEN`, 32, operand width; HI and LO are each XLEN bits.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: operation request, sampled only when `busy`=0.
- `op` in 3: operation code from the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `rs_val` in XLEN: register read operand 1 (dividend or multiplicand).
- `rt_val` in XLEN: register read operand 2 (divisor or multiplier).
- `flush` in 1: abort the in-flight operation (exception or branch kill).
- `busy` out 1: an iterative operation is in progress.
- `done` out 1: one-cycle pulse; HI/LO were updated on this edge.
- `hi` out XLEN: HI register.
- `lo` out XLEN: LO register.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch operands; take magnitudes for signed ops.
  - Record result signs: product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
  - Clear the counter and go to RUN.
- IDLE, `start`=1, op MTHI or MTLO:
  - Write `rs_val` into HI or LO at that edge and stay in IDLE.
  - `busy` and `done` stay 0.
- RUN: one radix-2 step per cycle, 6-bit counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - After step 31, go to FIX.
- FIX: apply two's-complement sign correction, then write the results.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - Pulse `done` and return to IDLE.
- Divide by zero, signed or unsigned: LO = 32'hFFFF_FFFF, HI = `rs_val`. Still takes the full latency.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- Unsigned ops never apply sign correction.
- `start` while `busy`=1 is ignored. Control logic must stall and not issue it.
- `flush`:
  - Forces IDLE on the next edge; HI/LO keep their prior values and no `done` pulse is produced.
  - `flush` has priority over a simultaneous `start`, so neither is accepted.
- `rst`: immediately sets state IDLE, counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0, including mid-operation.

## Timing

- Start accepted at edge N.
- `busy`=1 during cycles N+1 through N+33: 32 RUN cycles plus 1 FIX cycle.
- HI/LO update at the edge ending FIX, so new values and `done`=1 appear in cycle N+34, with `busy`=0.
- A back-to-back `start` is accepted in cycle N+34, the same cycle `done` is high.
- MTHI/MTLO: new value is visible in the cycle after the write edge.
- `hi`/`lo` are direct register outputs with no combinational path from inputs.
- `busy` is decoded from the state register only.

## Structure

- Package `md_pkg` holds:
  - `op` codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - The FSM state encoding.
  - The ITER=32 constant.
- Sub-module `md_step` is combinational: one multiply or divide iteration (accumulator/partial remainder in, next value out).
- `md_unit` holds the FSM, counter, operand/sign registers and HI/LO.

## Test plan

- MULT, rs=0xFFFF_FFFE (-2), rt=0x0000_0003 → `done` at N+34; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. Same operands with MULTU → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV, rs=0xFFFF_FFF9 (-7), rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU, rs=7, rt=2 → LO=3, HI=1.
- DIVU with rt=0, rs=0x1234_5678 → LO=0xFFFF_FFFF, HI=0x1234_5678. DIV 0x8000_0000 / -1 → LO=0x8000_0000, HI=0.
- MULT in flight with `flush` at N+10 → `busy`=0 at N+11, no `done`, HI/LO unchanged. Assert `rst` at N+5 → HI=LO=0 immediately.
- `start` asserted during `busy` → ignored, result matches the first op. MTLO rs=0xCAFE_F00D while idle → LO=0xCAFE_F00D next cycle, `done` stays 0.
